// File: rtl/config_port_arbiter.sv
// config_port_arbiter
// Shares the single fabric configuration write port between requester A
// (UART loader) and requester B (parallel/CPU loader). A requester keeps the
// port for a whole session. Every ownership change pulses FSM_Reset so the
// frame FSM resynchronises. Frame boundaries are tracked so that a release in
// the middle of a frame is flagged, and an owner that stops strobing is
// forcibly released after IdleTimeout granted cycles.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | no owner; arbitrate among raised Active lines
//   S_RESYNC   | owner chosen, FSM_Reset high for this one cycle, Ready low
//   S_GRANTED  | owner's words forwarded to the frame FSM
//   S_HANDOVER | one dead cycle after release, no strobes, Ready low
//
// After reset, A gets the first pick when both requesters ask together.

module config_port_arbiter #(
   parameter int unsigned NumberOfRows = 20,
   parameter int unsigned desync_flag  = 20,
   parameter logic [31:0] SYNC_WORD    = 32'hFAB0FAB1,
   parameter int unsigned IdleTimeout  = 1024,
   parameter int unsigned TimeoutWidth = 16
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        A_Active,
   input  logic [31:0] A_WriteData,
   input  logic        A_WriteStrobe,
   output logic        A_Ready,
   input  logic        B_Active,
   input  logic [31:0] B_WriteData,
   input  logic        B_WriteStrobe,
   output logic        B_Ready,
   output logic [31:0] WriteData,
   output logic        WriteStrobe,
   output logic        FSM_Reset,
   output logic [1:0]  Owner,
   output logic        FrameAborted,
   output logic        TimeoutError
);

   localparam int unsigned RowWidth = $clog2(NumberOfRows + 1);
   localparam logic [RowWidth-1:0]     RowLoad  = RowWidth'(NumberOfRows);
   localparam logic [RowWidth-1:0]     RowLast  = RowWidth'(1);
   // Idle timer is a down-counter: loaded with IdleTimeout-1, release at zero.
   localparam logic [TimeoutWidth-1:0] IdleLoad = TimeoutWidth'(IdleTimeout - 1);

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_A    = 2'b01;
   localparam logic [1:0] OWN_B    = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RESYNC   = 2'd1,
      S_GRANTED  = 2'd2,
      S_HANDOVER = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      P_UNSYNC = 2'd0,
      P_HEADER = 2'd1,
      P_DATA   = 2'd2
   } phase_t;

   state_t                  state;
   phase_t                  phase;
   logic [RowWidth-1:0]     row_cnt;
   logic [TimeoutWidth-1:0] idle_cnt;
   logic                    prio_b;

   logic        owner_active;
   logic        owner_strobe;
   logic [31:0] owner_data;
   logic        idle_tc;
   logic        release_now;
   logic        port_open;
   logic        take;
   logic        grant_a;
   logic        grant_b;
   logic        enter_resync;

   // Select the current owner's request lines.
   always_comb begin
      owner_active = 1'b0;
      owner_strobe = 1'b0;
      owner_data   = '0;
      case (Owner)
         OWN_A: begin
            owner_active = A_Active;
            owner_strobe = A_WriteStrobe;
            owner_data   = A_WriteData;
         end
         OWN_B: begin
            owner_active = B_Active;
            owner_strobe = B_WriteStrobe;
            owner_data   = B_WriteData;
         end
         default: ;
      endcase
   end

   // Release is decided combinationally so Ready drops in the deciding cycle.
   assign idle_tc      = (idle_cnt == '0);
   assign release_now  = (state == S_GRANTED) && (!owner_active || idle_tc);
   assign port_open    = (state == S_GRANTED) && !release_now;
   assign A_Ready      = port_open && (Owner == OWN_A);
   assign B_Ready      = port_open && (Owner == OWN_B);
   assign take         = port_open && owner_strobe;

   // prio_b=1 means B wins a tie; it flips to the other side on every grant.
   assign grant_a      = A_Active && (!B_Active || !prio_b);
   assign grant_b      = B_Active && (!A_Active || prio_b);
   assign enter_resync = (state == S_IDLE) && (A_Active || B_Active);

   // Ownership FSM with registered Owner and FSM_Reset.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= S_IDLE;
         Owner        <= OWN_NONE;
         FSM_Reset    <= 1'b0;
         prio_b       <= 1'b0;
         FrameAborted <= 1'b0;
         TimeoutError <= 1'b0;
      end else begin
         FSM_Reset <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_a) begin
                  Owner     <= OWN_A;
                  prio_b    <= 1'b1;
                  FSM_Reset <= 1'b1;
                  state     <= S_RESYNC;
               end else if (grant_b) begin
                  Owner     <= OWN_B;
                  prio_b    <= 1'b0;
                  FSM_Reset <= 1'b1;
                  state     <= S_RESYNC;
               end
            end
            S_RESYNC: begin
               state <= S_GRANTED;
            end
            S_GRANTED: begin
               if (release_now) begin
                  state <= S_HANDOVER;
                  if (idle_tc) begin
                     TimeoutError <= 1'b1;
                  end
                  if (phase == P_DATA) begin
                     FrameAborted <= 1'b1;
                  end
               end
            end
            S_HANDOVER: begin
               Owner <= OWN_NONE;
               state <= S_IDLE;
            end
            default: begin
               Owner <= OWN_NONE;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Forward accepted owner words with one cycle of latency; data holds otherwise.
   always_ff @(posedge CLK) begin
      if (reset) begin
         WriteData   <= '0;
         WriteStrobe <= 1'b0;
      end else begin
         WriteStrobe <= take;
         if (take) begin
            WriteData <= owner_data;
         end
      end
   end

   // Idle down-counter: reloads on every accepted word and outside GRANTED, stops at zero.
   always_ff @(posedge CLK) begin
      if (reset) begin
         idle_cnt <= IdleLoad;
      end else if ((state != S_GRANTED) || take) begin
         idle_cnt <= IdleLoad;
      end else if (!idle_tc) begin
         idle_cnt <= idle_cnt - 1'b1;
      end
   end

   // Frame phase tracker, advanced only by accepted words; restarts for each new owner.
   always_ff @(posedge CLK) begin
      if (reset) begin
         phase   <= P_UNSYNC;
         row_cnt <= '0;
      end else if (enter_resync) begin
         phase   <= P_UNSYNC;
         row_cnt <= '0;
      end else if (take) begin
         case (phase)
            P_UNSYNC: begin
               if (owner_data == SYNC_WORD) begin
                  phase <= P_HEADER;
               end
            end
            P_HEADER: begin
               if (owner_data[desync_flag]) begin
                  phase <= P_UNSYNC;
               end else begin
                  phase   <= P_DATA;
                  row_cnt <= RowLoad;
               end
            end
            P_DATA: begin
               if (row_cnt == RowLast) begin
                  phase <= P_HEADER;
               end
               row_cnt <= row_cnt - 1'b1;
            end
            default: phase <= P_UNSYNC;
         endcase
      end
   end

endmodule
